jk_bank_driver: RTL and testbench

- Write-side controller for a bank of WIDTH positive-edge JK flip-flops sharing this block's clock.
- Accepts a target word on a valid/ready handshake and converts it, through the JK excitation table, into J/K vectors for the bank.
- Applies the J/K vectors for exactly one cycle, reads the bank output back and compares it against the target.
- Retries up to MAX_RETRY times on mismatch, then reports done or err to the upstream sequencer.

---
 rtl/jk_bank_pkg.sv | 22 ++
 rtl/jk_bank_driver_if.sv | 21 ++
 rtl/jk_exc_encode.sv | 23 ++
 rtl/jk_bank_driver.sv | 104 ++++++++++
 tb/tb_jk_bank_driver.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/jk_bank_pkg.sv
// Shared types and constants for the JK bank write driver: FSM states, {j,k} excitation codes,
// and the width of the attempts counter.
package jk_bank_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      CHECK  = 2'd2,
      REPORT = 2'd3
   } state_e;

   // Codes are ordered {j,k}.
   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_CLR  = 2'b01;
   localparam logic [1:0] JK_TGL  = 2'b11;

   function automatic int att_width(input int max_retry);
      return $clog2(max_retry + 2);
   endfunction

endpackage

// File: rtl/jk_bank_driver_if.sv
// Sequencer-side link to the JK bank driver: target handshake plus done/err/attempts report.
// master = upstream sequencer, slave = driver.
interface jk_bank_driver_if #(
   parameter int WIDTH     = 8,
   parameter int MAX_RETRY = 2
) ();
   import jk_bank_pkg::*;

   localparam int AW = att_width(MAX_RETRY);

   logic             tgt_valid;
   logic [WIDTH-1:0] tgt_data;
   logic             tgt_ready;
   logic             done;
   logic             err;
   logic [AW-1:0]    attempts;

   modport master (output tgt_valid, tgt_data, input tgt_ready, done, err, attempts);
   modport slave  (input tgt_valid, tgt_data, output tgt_ready, done, err, attempts);

endinterface

// File: rtl/jk_exc_encode.sv
// Combinational JK excitation: maps current bit q and target bit t to {j,k}, zero latency.
// JK_TOGGLE_FILL_EN selects toggle fill (changed bits j=k=1); otherwise don't-cares resolve to 0.
module jk_exc_encode
   import jk_bank_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] t_i,
   output logic [WIDTH-1:0] j_o,
   output logic [WIDTH-1:0] k_o
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
`ifdef JK_TOGGLE_FILL_EN
      assign {j_o[i], k_o[i]} = (q_i[i] ^ t_i[i]) ? JK_TGL : JK_HOLD;
`else
      assign {j_o[i], k_o[i]} = (q_i[i] == t_i[i]) ? JK_HOLD
                              : (t_i[i] ? JK_SET : JK_CLR);
`endif
   end

endmodule

// File: rtl/jk_bank_driver.sv
// Write-side controller for a JK flop bank: accept target, drive j/k for one cycle, read back,
// retry up to MAX_RETRY times, pulse done/err. tgt_ready only in IDLE (fill mode: JK_TOGGLE_FILL_EN).
module jk_bank_driver
   import jk_bank_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MAX_RETRY = 2
) (
   input  logic             clk,
   input  logic             reset,
   jk_bank_driver_if.slave  bus,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] j,
   output logic [WIDTH-1:0] k
);

   localparam int            AW       = att_width(MAX_RETRY);
   localparam logic [AW-1:0] ATT_LAST = AW'(MAX_RETRY);
   localparam logic [AW-1:0] ATT_ONE  = AW'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
   logic             done_q, done_d, err_q, err_d;
   logic [AW-1:0]    att_q, att_d;

   logic [WIDTH-1:0] enc_t, enc_j, enc_k;

   // First attempt encodes against the incoming word; retries against the captured target.
   assign enc_t = (state_q == IDLE) ? bus.tgt_data : tgt_q;

   jk_exc_encode #(.WIDTH(WIDTH)) u_enc (
      .q_i (q_fb),
      .t_i (enc_t),
      .j_o (enc_j),
      .k_o (enc_k)
   );

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      j_d     = '0;
      k_d     = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      att_d   = att_q;
      case (state_q)
         IDLE: begin
            if (bus.tgt_valid) begin
               tgt_d   = bus.tgt_data;
               j_d     = enc_j;
               k_d     = enc_k;
               att_d   = ATT_ONE;
               state_d = APPLY;
            end
         end
         APPLY: state_d = CHECK;
         CHECK: begin
            if (q_fb == tgt_q) begin
               done_d  = 1'b1;
               state_d = REPORT;
            end else if (att_q <= ATT_LAST) begin
               j_d     = enc_j;
               k_d     = enc_k;
               att_d   = att_q + ATT_ONE;
               state_d = APPLY;
            end else begin
               err_d   = 1'b1;
               state_d = REPORT;
            end
         end
         REPORT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         tgt_q   <= '0;
         j_q     <= '0;
         k_q     <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         att_q   <= '0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         j_q     <= j_d;
         k_q     <= k_d;
         done_q  <= done_d;
         err_q   <= err_d;
         att_q   <= att_d;
      end
   end

   assign bus.tgt_ready = (state_q == IDLE);
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.attempts  = att_q;
   assign j             = j_q;
   assign k             = k_q;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: WIDTH=4 bank of behavioural JK flops with stuck/transient fault hooks,
// scoreboard of expected reports checked when done/err appears.
module tb_jk_bank_driver;
   import jk_bank_pkg::*;

   localparam int W  = 4;
   localparam int MR = 2;
   localparam int AW = att_width(MR);

   typedef struct {
      logic          dn;
      logic          er;
      logic [AW-1:0] att;
      logic [W-1:0]  bank;
      int            lat;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] bank = '0;
   logic [W-1:0] load_val = '0;
   logic         load = 1'b0, freeze = 1'b0, stuck0 = 1'b0;
   logic [W-1:0] q_fb, j, k;

   int n_chk = 0, n_pass = 0, n_fail = 0;
   int done_cnt = 0, err_cnt = 0, jk_nz_cnt = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   jk_bank_driver_if #(.WIDTH(W), .MAX_RETRY(MR)) bus ();

   jk_bank_driver #(.WIDTH(W), .MAX_RETRY(MR)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .q_fb  (q_fb),
      .j     (j),
      .k     (k)
   );

   // Behavioural JK bank; bit0 readback can be forced low, and one update can be suppressed.
   assign q_fb = stuck0 ? {bank[W-1:1], 1'b0} : bank;

   always @(posedge clk) begin
      if (load) bank <= load_val;
      else if (!freeze) begin
         for (int i = 0; i < W; i++) begin
            case ({j[i], k[i]})
               2'b10:   bank[i] <= 1'b1;
               2'b01:   bank[i] <= 1'b0;
               2'b11:   bank[i] <= ~bank[i];
               default: bank[i] <= bank[i];
            endcase
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (bus.done) done_cnt++;
      if (bus.err) err_cnt++;
      if ((j | k) != '0) jk_nz_cnt++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic dn, input logic er, input int att,
                               input logic [W-1:0] b, input int lat);
      exp_t e;
      e.dn = dn; e.er = er; e.att = AW'(att); e.bank = b; e.lat = lat;
      return e;
   endfunction

   task automatic load_bank(input logic [W-1:0] v);
      load = 1'b1; load_val = v;
      @(negedge clk);
      load = 1'b0;
   endtask

   // Called at a negedge in IDLE; returns at the APPLY-cycle negedge.
   task automatic send(input logic [W-1:0] t, input bit push, input exp_t e);
      bus.tgt_valid = 1'b1;
      bus.tgt_data  = t;
      if (push) sb.push_back(e);
      @(negedge clk);
      bus.tgt_valid = 1'b0;
      bus.tgt_data  = W'($urandom);
   endtask

   task automatic wait_report(input string tag);
      exp_t e;
      bit   seen = 0;
      int   n = 0;
      chk({tag, "_sb_depth"}, sb.size(), 1);
      e = (sb.size() > 0) ? sb.pop_front() : mk(1'b1, 1'b0, 0, '0, 0);
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(negedge clk);
         n = i;
         if (bus.done || bus.err) seen = 1;
      end
      chk({tag, "_seen"}, seen, 1);
      chk({tag, "_lat"}, n, e.lat);
      chk({tag, "_done"}, bus.done, e.dn);
      chk({tag, "_err"}, bus.err, e.er);
      chk({tag, "_att"}, bus.attempts, e.att);
      chk({tag, "_bank"}, q_fb, e.bank);
      @(negedge clk);
      chk({tag, "_ready_after"}, bus.tgt_ready, 1);
      chk({tag, "_pulse_end"}, bus.done | bus.err, 0);
      chk({tag, "_att_hold"}, bus.attempts, e.att);
   endtask

   initial begin
      int d0, e0, nz0;
      logic [W-1:0] exp_j, exp_k;
      bus.tgt_valid = 1'b0;
      bus.tgt_data  = '0;

      // 1: reset release, idle hold
      load_bank(4'b0110);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_ready", bus.tgt_ready, 1);
      chk("rst_j", j, 0);
      chk("rst_k", k, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_att", bus.attempts, 0);
      repeat (2) @(negedge clk);
      chk("rst_bank_hold", q_fb, 4'b0110);

      // 2: 0101 -> 0011
      load_bank(4'b0101);
`ifdef JK_TOGGLE_FILL_EN
      exp_j = 4'b0110; exp_k = 4'b0110;
`else
      exp_j = 4'b0010; exp_k = 4'b0100;
`endif
      send(4'b0011, 1, mk(1'b1, 1'b0, 1, 4'b0011, 2));
      chk("t2_j", j, exp_j);
      chk("t2_k", k, exp_k);
      chk("t2_ready_low", bus.tgt_ready, 0);
      wait_report("t2");

      // 3: target equals bank
      load_bank(4'b1010);
      send(4'b1010, 1, mk(1'b1, 1'b0, 1, 4'b1010, 2));
      chk("t3_j", j, 0);
      chk("t3_k", k, 0);
      wait_report("t3");

      // 4: bit0 stuck at 0 -> retries exhausted
      load_bank(4'b0000);
      stuck0 = 1'b1;
      d0 = done_cnt; e0 = err_cnt; nz0 = jk_nz_cnt;
`ifdef JK_TOGGLE_FILL_EN
      exp_k = 4'b0001;
`else
      exp_k = 4'b0000;
`endif
      send(4'b0001, 1, mk(1'b0, 1'b1, 3, 4'b0000, 6));
      chk("t4_j", j, 4'b0001);
      chk("t4_k", k, exp_k);
      wait_report("t4");
      chk("t4_apply_phases", jk_nz_cnt - nz0, 3);
      chk("t4_done_pulses", done_cnt - d0, 0);
      chk("t4_err_pulses", err_cnt - e0, 1);
      stuck0 = 1'b0;

      // 5: first apply lost, second succeeds
      load_bank(4'b0100);
      freeze = 1'b1;
`ifdef JK_TOGGLE_FILL_EN
      exp_k = 4'b0011;
`else
      exp_k = 4'b0000;
`endif
      send(4'b0111, 1, mk(1'b1, 1'b0, 2, 4'b0111, 3));
      chk("t5_j", j, 4'b0011);
      chk("t5_k", k, exp_k);
      @(negedge clk);
      freeze = 1'b0;
      wait_report("t5");

      // 6: reset during CHECK aborts, then a fresh request completes
      load_bank(4'b0000);
      d0 = done_cnt; e0 = err_cnt;
      send(4'b1111, 0, mk(1'b0, 1'b0, 0, '0, 0));
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("t6_rst_j", j, 0);
      chk("t6_rst_k", k, 0);
      chk("t6_rst_ready", bus.tgt_ready, 1);
      chk("t6_rst_att", bus.attempts, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("t6_no_done", done_cnt - d0, 0);
      chk("t6_no_err", err_cnt - e0, 0);
      chk("t6_bank_held", q_fb, 4'b1111);
`ifdef JK_TOGGLE_FILL_EN
      exp_j = 4'b1001; exp_k = 4'b1001;
`else
      exp_j = 4'b0000; exp_k = 4'b1001;
`endif
      send(4'b0110, 1, mk(1'b1, 1'b0, 1, 4'b0110, 2));
      chk("t6_j", j, exp_j);
      chk("t6_k", k, exp_k);
      wait_report("t6");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
